pe_mac_bank: RTL and testbench

Parametrised fixed-point processing element with a registered multiplier, a bank of NUM_ACC independent wide accumulators, and a round/saturate output stage. It extends the basic PE with several features:
- valid/ready handshakes on input and output
- per-term clear and flush (read-and-clear) of the selected accumulator
- selectable rounding mode
- optional saturation with an overflow flag

It sits in the PE array between the operand feeders and the result collector.

---
 rtl/pe_mac_bank.sv | 222 ++++++++++++++++++++++
 tb/tb_pe_mac_bank.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_bank.sv
// pe_mac_bank
// Fixed-point multiply-accumulate processing element with a bank of
// independent wide accumulators and a round/saturate output stage. It sits in
// the PE array between the operand feeders and the result collector.
//
// Each accepted term passes through four register stages:
//   S0  operand/control capture
//   S1  registered signed product
//   S2  accumulate into the selected bank entry, keep the sum
//   S3  rounded/saturated result register (flush terms only)
// A flush term accepted at edge T therefore shows out_valid after edge T+3.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready term handshake
//   data_a, data_b    signed Q(INT_BITS.FRAC_BITS) operands
//   acc_sel           accumulator addressed by the term
//   acc_clear         use 0 instead of the stored accumulator as addend
//   acc_flush         emit the rounded sum and zero the accumulator
//   round_mode        0 = truncate (floor), 1 = round-half-up
//   sat_en            1 = clamp on overflow, 0 = wrap
//   out_valid/out_ready result handshake
//   out_data, out_idx result and the accumulator that produced it
//   out_ovf           result did not fit in the signed W-bit range

module pe_mac_bank #(
   parameter int INT_BITS   = 7,
   parameter int FRAC_BITS  = 9,
   parameter int NUM_ACC    = 8,
   parameter int GUARD_BITS = 4,
   localparam int W  = INT_BITS + FRAC_BITS,
   localparam int AW = 2 * W + GUARD_BITS,
   localparam int SW = $clog2(NUM_ACC)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  data_a,
   input  logic [W-1:0]  data_b,
   input  logic [SW-1:0] acc_sel,
   input  logic          acc_clear,
   input  logic          acc_flush,
   input  logic          round_mode,
   input  logic          sat_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [SW-1:0] out_idx,
   output logic          out_ovf
);

   // Only sum[AW-1:FRAC_BITS-1] matters to the output stage: the top bits give
   // the truncated result and bit FRAC_BITS-1 is the round-half-up carry.
   localparam int TW = AW - FRAC_BITS + 1;

   // S0: captured term
   logic          s0_valid;
   logic [W-1:0]  s0_a;
   logic [W-1:0]  s0_b;
   logic [SW-1:0] s0_sel;
   logic          s0_clear;
   logic          s0_flush;
   logic          s0_round;
   logic          s0_sat;

   // S1: product plus control
   logic          s1_valid;
   logic [2*W-1:0] s1_prod;
   logic [SW-1:0] s1_sel;
   logic          s1_clear;
   logic          s1_flush;
   logic          s1_round;
   logic          s1_sat;

   // S2: accumulated sum plus control
   logic          s2_valid;
   logic [TW-1:0] s2_top;
   logic [SW-1:0] s2_sel;
   logic          s2_flush;
   logic          s2_round;
   logic          s2_sat;

   logic [AW-1:0] acc [NUM_ACC];

   logic          stall;
   logic [2*W-1:0] prod_full;
   logic [AW-1:0] addend;
   logic [AW-1:0] sum;
   logic [TW-1:0] r_val;
   logic [TW-W:0] r_hi;
   logic          r_ovf;
   logic [W-1:0]  r_data;

   // The pipeline only has to stop when a finished flush result in S2 has
   // nowhere to go because S3 still holds an unconsumed result. Non-flush
   // terms never need S3, so they keep moving while the output waits.
   assign stall    = out_valid && !out_ready && s2_valid && s2_flush;
   assign in_ready = !stall;

   // Both operands are sign-extended to 2W bits so the 2W-bit product of the
   // extended values equals the exact signed product.
   assign prod_full = $signed({{W{s0_a[W-1]}}, s0_a}) * $signed({{W{s0_b[W-1]}}, s0_b});

   // S0 captures the incoming term whenever the pipeline advances. The valid
   // bit alone decides whether the captured fields mean anything, so control
   // inputs seen with in_valid low have no effect.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_valid <= 1'b0;
         s0_a     <= '0;
         s0_b     <= '0;
         s0_sel   <= '0;
         s0_clear <= 1'b0;
         s0_flush <= 1'b0;
         s0_round <= 1'b0;
         s0_sat   <= 1'b0;
      end else if (!stall) begin
         s0_valid <= in_valid;
         s0_a     <= data_a;
         s0_b     <= data_b;
         s0_sel   <= acc_sel;
         s0_clear <= acc_clear;
         s0_flush <= acc_flush;
         s0_round <= round_mode;
         s0_sat   <= sat_en;
      end
   end

   // S1 registers the product and carries the term's control fields along,
   // so a later change of round_mode or sat_en cannot touch this term.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_prod  <= '0;
         s1_sel   <= '0;
         s1_clear <= 1'b0;
         s1_flush <= 1'b0;
         s1_round <= 1'b0;
         s1_sat   <= 1'b0;
      end else if (!stall) begin
         s1_valid <= s0_valid;
         s1_prod  <= prod_full;
         s1_sel   <= s0_sel;
         s1_clear <= s0_clear;
         s1_flush <= s0_flush;
         s1_round <= s0_round;
         s1_sat   <= s0_sat;
      end
   end

   // The addend is read straight from the bank in the same cycle that S2
   // writes it back. Because this is the only reader and writer, a term that
   // immediately follows another on the same accumulator sees the new sum.
   always_comb begin
      addend = s1_clear ? '0 : acc[s1_sel];
      sum    = {{GUARD_BITS{s1_prod[2*W-1]}}, s1_prod} + addend;
   end

   // S2 updates the addressed accumulator (zeroing it on flush) and keeps the
   // bits of the sum that the output stage needs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_top   <= '0;
         s2_sel   <= '0;
         s2_flush <= 1'b0;
         s2_round <= 1'b0;
         s2_sat   <= 1'b0;
         for (int i = 0; i < NUM_ACC; i++) begin
            acc[i] <= '0;
         end
      end else if (!stall) begin
         s2_valid <= s1_valid;
         s2_top   <= sum[AW-1:FRAC_BITS-1];
         s2_sel   <= s1_sel;
         s2_flush <= s1_flush;
         s2_round <= s1_round;
         s2_sat   <= s1_sat;
         if (s1_valid) begin
            acc[s1_sel] <= s1_flush ? '0 : sum;
         end
      end
   end

   // Adding half an LSB and shifting is the same as shifting and then adding
   // the first discarded bit, which avoids a full-width adder on the low bits
   // and can never overflow the AW+1-FRAC_BITS result. The result fits in W
   // bits only when all bits from W-1 upward are copies of the sign.
   always_comb begin
      r_val = {s2_top[TW-1], s2_top[TW-1:1]} + TW'(s2_round & s2_top[0]);
      r_hi  = r_val[TW-1:W-1];
      r_ovf = !((&r_hi) || !(|r_hi));
      if (r_ovf && s2_sat) begin
         r_data = {r_val[TW-1], {(W-1){~r_val[TW-1]}}};
      end else begin
         r_data = r_val[W-1:0];
      end
   end

   // S3 loads only for flush terms. A new result may replace one that is
   // being consumed on the same edge; otherwise out_valid drops once the
   // collector takes the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_idx   <= '0;
         out_ovf   <= 1'b0;
      end else if (!stall) begin
         if (s2_valid && s2_flush) begin
            out_valid <= 1'b1;
            out_data  <= r_data;
            out_idx   <= s2_sel;
            out_ovf   <= r_ovf;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pe_mac_bank.sv
// tb_pe_mac_bank
// Self-checking bench for pe_mac_bank. A reference model works on whole terms
// at handshake time with plain integer arithmetic and queues the results it
// expects; a monitor compares every consumed result against that queue.
// Directed sequences add fixed expected values and latency/backpressure checks.

module tb_pe_mac_bank;

   localparam int INT_BITS   = 7;
   localparam int FRAC_BITS  = 9;
   localparam int NUM_ACC    = 8;
   localparam int GUARD_BITS = 4;
   localparam int W  = INT_BITS + FRAC_BITS;
   localparam int AW = 2 * W + GUARD_BITS;
   localparam int SW = $clog2(NUM_ACC);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  data_a;
   logic [W-1:0]  data_b;
   logic [SW-1:0] acc_sel;
   logic          acc_clear;
   logic          acc_flush;
   logic          round_mode;
   logic          sat_en;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_idx;
   logic          out_ovf;

   typedef struct packed {
      logic [W-1:0]  data;
      logic [SW-1:0] idx;
      logic          ovf;
   } result_t;

   int      numCompared   = 0;
   int      numMismatched = 0;
   longint  accModel [NUM_ACC];
   result_t expQ [$];
   bit      heldValid = 1'b0;
   result_t heldWord;
   bit      randReady = 1'b0;

   pe_mac_bank #(
      .INT_BITS   (INT_BITS),
      .FRAC_BITS  (FRAC_BITS),
      .NUM_ACC    (NUM_ACC),
      .GUARD_BITS (GUARD_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_a     (data_a),
      .data_b     (data_b),
      .acc_sel    (acc_sel),
      .acc_clear  (acc_clear),
      .acc_flush  (acc_flush),
      .round_mode (round_mode),
      .sat_en     (sat_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_idx    (out_idx),
      .out_ovf    (out_ovf)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      numCompared++;
      if (observed !== expected) begin
         numMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Keep AW bits of an accumulator value, sign-extended to 64 bits.
   function automatic longint wrapAcc(input longint v);
      return (v <<< (64 - AW)) >>> (64 - AW);
   endfunction

   // Reference behaviour of one accepted term.
   function automatic void modelTerm(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [SW-1:0] sel, input logic clr,
                                     input logic fl, input logic rm, input logic st);
      longint  prod;
      longint  s;
      longint  r;
      result_t e;
      prod = longint'($signed(a)) * longint'($signed(b));
      s    = wrapAcc(prod + (clr ? 64'sd0 : accModel[sel]));
      accModel[sel] = fl ? 64'sd0 : s;
      if (fl) begin
         if (rm) r = (s + (64'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
         else    r = s >>> FRAC_BITS;
         e.idx = sel;
         e.ovf = (r > ((64'sd1 <<< (W - 1)) - 1)) || (r < -(64'sd1 <<< (W - 1)));
         if (e.ovf && st) e.data = (r < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
         else             e.data = r[W-1:0];
         expQ.push_back(e);
      end
   endfunction

   // Monitor: at each falling edge look at what the next rising edge will
   // do: a consumed result is checked against the model, an accepted term is
   // fed to the model, and a held result must not change.
   always @(negedge clk) begin
      result_t e;
      if (!rst_n) begin
         expQ.delete();
         foreach (accModel[i]) accModel[i] = 0;
         heldValid = 1'b0;
      end else begin
         if (heldValid) begin
            checkOutput("hold_valid", 64'(out_valid), 64'd1);
            checkOutput("hold_result", 64'({out_data, out_idx, out_ovf}), 64'(heldWord));
         end
         heldValid = out_valid && !out_ready;
         heldWord  = {out_data, out_idx, out_ovf};
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_result", 64'd1, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("out_data", 64'(out_data), 64'(e.data));
               checkOutput("out_idx", 64'(out_idx), 64'(e.idx));
               checkOutput("out_ovf", 64'(out_ovf), 64'(e.ovf));
            end
         end
         if (in_valid && in_ready) begin
            modelTerm(data_a, data_b, acc_sel, acc_clear, acc_flush, round_mode, sat_en);
         end
      end
   end

   // Random backpressure during the random phase.
   always @(posedge clk) begin
      if (randReady) begin
         #1;
         out_ready = ($urandom_range(0, 9) < 7);
      end
   end

   // Present one term and hold it until it is accepted (bounded).
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [SW-1:0] sel, input logic clr,
                                input logic fl, input logic rm, input logic st);
      int waitCycles = 0;
      data_a     = a;
      data_b     = b;
      acc_sel    = sel;
      acc_clear  = clr;
      acc_flush  = fl;
      round_mode = rm;
      sat_en     = st;
      in_valid   = 1'b1;
      @(negedge clk);
      while (!in_ready && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!in_ready) checkOutput("in_ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Wait (bounded) until out_valid is seen at a falling edge; k counts the
   // rising edges passed since the call.
   task automatic waitResult(output int k);
      k = 0;
      @(negedge clk);
      while (!out_valid && k < 20) begin
         k++;
         @(negedge clk);
      end
      if (!out_valid) checkOutput("result_timeout", 64'd0, 64'd1);
   endtask

   task automatic checkResult(input string tag, input logic [W-1:0] expData,
                              input logic [SW-1:0] expIdx, input logic expOvf);
      checkOutput({tag, "_data"}, 64'(out_data), 64'(expData));
      checkOutput({tag, "_idx"}, 64'(out_idx), 64'(expIdx));
      checkOutput({tag, "_ovf"}, 64'(out_ovf), 64'(expOvf));
   endtask

   // Single flush term on an idle pipeline: fixed latency and fixed result.
   task automatic flushAndCheck(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [SW-1:0] sel, input logic clr, input logic rm,
                                input logic st, input logic [W-1:0] expData, input logic expOvf);
      int k;
      applyStimulus(a, b, sel, clr, 1'b1, rm, st);
      waitResult(k);
      checkOutput({tag, "_latency"}, 64'(k), 64'd3);
      checkResult(tag, expData, sel, expOvf);
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      checkOutput({tag, "_out_data"}, 64'(out_data), 64'd0);
      checkOutput({tag, "_out_idx"}, 64'(out_idx), 64'd0);
      checkOutput({tag, "_out_ovf"}, 64'(out_ovf), 64'd0);
      checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   initial begin
      int k;
      int waitCycles;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      data_a     = '0;
      data_b     = '0;
      acc_sel    = '0;
      acc_clear  = 1'b0;
      acc_flush  = 1'b0;
      round_mode = 1'b0;
      sat_en     = 1'b0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checkResetState("reset");

      // Accumulate then flush on accumulator 3; it must read 0 afterwards.
      applyStimulus(16'h0200, 16'h0300, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      flushAndCheck("acc3_flush", 16'h0200, 16'h0100, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0400, 1'b0);
      flushAndCheck("acc3_after", 16'h0000, 16'h0000, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);

      // Rounding boundaries at exactly one half LSB.
      flushAndCheck("rnd_pos_trunc", 16'h0001, 16'h0100, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      flushAndCheck("rnd_pos_round", 16'h0001, 16'h0100, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0001, 1'b0);
      flushAndCheck("rnd_neg_trunc", 16'hFFFF, 16'h0100, 3'd5, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0);
      flushAndCheck("rnd_neg_round", 16'hFFFF, 16'h0100, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);

      // Overflow with and without saturation.
      flushAndCheck("sat_pos", 16'h7FFF, 16'h7FFF, 3'd6, 1'b1, 1'b0, 1'b1, 16'h7FFF, 1'b1);
      flushAndCheck("wrap_pos", 16'h7FFF, 16'h7FFF, 3'd6, 1'b1, 1'b0, 1'b0, 16'hFF80, 1'b1);
      flushAndCheck("sat_neg", 16'h8000, 16'h7FFF, 3'd6, 1'b1, 1'b0, 1'b1, 16'h8000, 1'b1);

      // Interleaved accumulation on 0 and 1, then back-to-back flushes.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(16'h0200, 16'h0200, 3'd0, (i == 0), 1'b0, 1'b0, 1'b0);
         applyStimulus(16'h0200, 16'hFE00, 3'd1, (i == 0), 1'b0, 1'b0, 1'b0);
      end
      applyStimulus(16'h0000, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0000, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      waitResult(k);
      checkResult("ilv_acc0", 16'h1000, 3'd0, 1'b0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("ilv_b2b_valid", 64'(out_valid), 64'd1);
      checkResult("ilv_acc1", 16'hF000, 3'd1, 1'b0);
      idle(4);

      // Backpressure: three flushes with the collector stalled.
      out_ready = 1'b0;
      applyStimulus(16'h0400, 16'h0200, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0300, 16'h0200, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'hFE00, 16'h0400, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(6);
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkResult("bp_first", 16'h0400, 3'd2, 1'b0);
      out_ready = 1'b1;
      idle(8);
      checkOutput("bp_all_delivered", 64'(expQ.size()), 64'd0);
      checkOutput("bp_in_ready_after", 64'(in_ready), 64'd1);

      // Reset in the middle of traffic with a result held at the output.
      out_ready = 1'b0;
      applyStimulus(16'h0200, 16'h0200, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      applyStimulus(16'h0400, 16'h0400, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h0100, 16'h0200, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(5);
      checkResult("pre_reset_held", 16'h0200, 3'd3, 1'b0);
      data_a    = 16'h0400;
      data_b    = 16'h0400;
      acc_sel   = 3'd1;
      acc_clear = 1'b0;
      acc_flush = 1'b1;
      in_valid  = 1'b1;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checkResetState("mid_reset");
      flushAndCheck("rst_acc7", 16'h0000, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
      flushAndCheck("rst_acc1", 16'h0200, 16'h0200, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0200, 1'b0);

      // Random traffic with random backpressure against the model.
      randReady = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
         end else begin
            ra = 16'($urandom_range(0, 4095)) - 16'd2048;
            rb = 16'($urandom_range(0, 4095)) - 16'd2048;
         end
         applyStimulus(ra, rb, 3'($urandom_range(0, NUM_ACC - 1)),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 7) == 0) idle(1);
      end
      randReady = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      waitCycles = 0;
      while ((expQ.size() != 0 || out_valid) && waitCycles < 100) begin
         @(posedge clk);
         waitCycles++;
      end
      #1;
      checkOutput("random_drained", 64'(expQ.size()), 64'd0);
      checkOutput("random_out_idle", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
      $finish;
   end

endmodule
